// File: rtl/edge_detect_array.sv
// Multi-channel synchronising edge detector: per-channel synchroniser, run-length glitch filter,
// and qualified edge reporting as a pulse, a sticky flag and a saturating counter.
module edge_detect_array #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 1,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter bit          RESET_LEVEL = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CHANNELS-1:0]             async_in,
  input  logic [2*CHANNELS-1:0]           mode,
  input  logic [CHANNELS-1:0]             clear,
  output logic [CHANNELS-1:0]             level,
  output logic [CHANNELS-1:0]             edge_pulse,
  output logic [CHANNELS-1:0]             edge_sticky,
  output logic [CHANNELS*CNT_WIDTH-1:0]   edge_count,
  output logic [CHANNELS-1:0]             overflow
);

  localparam int unsigned RunW = $clog2(FILTER_LEN + 1);
  localparam logic [RunW-1:0]      RunLast = RunW'(FILTER_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CntMax  = '1;

  logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0][RunW-1:0]        run_q, run_d;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0]   count_q, count_d;
  logic [CHANNELS-1:0]                  level_q, level_d;
  logic [CHANNELS-1:0]                  pulse_q, pulse_d;
  logic [CHANNELS-1:0]                  sticky_q, sticky_d;
  logic [CHANNELS-1:0]                  ovf_q, ovf_d;
  logic [CHANNELS-1:0]                  s_w, chg_w, qual_w;

  always_comb begin
    sync_d   = sync_q;
    run_d    = run_q;
    count_d  = count_q;
    level_d  = level_q;
    pulse_d  = '0;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    s_w      = '0;
    chg_w    = '0;
    qual_w   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], async_in[i]};
      s_w[i]    = sync_q[i][SYNC_STAGES-1];

      if (s_w[i] != level_q[i]) begin
        if (run_q[i] == RunLast) begin
          level_d[i] = s_w[i];
          run_d[i]   = '0;
          chg_w[i]   = 1'b1;
        end else begin
          run_d[i] = run_q[i] + RunW'(1);
        end
      end else begin
        run_d[i] = '0;
      end

      qual_w[i] = chg_w[i] & ((s_w[i] & mode[2*i]) | (~s_w[i] & mode[2*i+1]));

      if (clear[i]) begin
        sticky_d[i] = 1'b0;
        count_d[i]  = '0;
        ovf_d[i]    = 1'b0;
      end

      // A clear coinciding with an edge still records that edge as the first one.
      if (qual_w[i]) begin
        pulse_d[i]  = 1'b1;
        sticky_d[i] = 1'b1;
        if (clear[i]) begin
          count_d[i] = CNT_WIDTH'(1);
        end else if (count_q[i] == CntMax) begin
          ovf_d[i] = 1'b1;
        end else begin
          count_d[i] = count_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= {(CHANNELS*SYNC_STAGES){RESET_LEVEL}};
      run_q    <= '0;
      count_q  <= '0;
      level_q  <= {CHANNELS{RESET_LEVEL}};
      pulse_q  <= '0;
      sticky_q <= '0;
      ovf_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      run_q    <= run_d;
      count_q  <= count_d;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

  assign level       = level_q;
  assign edge_pulse  = pulse_q;
  assign edge_sticky = sticky_q;
  assign edge_count  = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_edge_detect_array.sv
// Directed bench for edge_detect_array: a default instance and a FILTER_LEN=3 / CNT_WIDTH=2
// instance, with a pulse scoreboard checked every cycle plus directed state checks.
module tb_edge_detect_array;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] a_in, a_clear, a_level, a_pulse, a_sticky, a_ovf;
  logic [3:0] a_mode;
  logic [15:0] a_count;
  logic [1:0] b_in, b_clear, b_level, b_pulse, b_sticky, b_ovf;
  logic [3:0] b_mode;
  logic [3:0] b_count;

  typedef struct {
    int ch;
    int cyc;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  edge_detect_array dut_a (
    .clk        (clk),
    .rst        (rst),
    .async_in   (a_in),
    .mode       (a_mode),
    .clear      (a_clear),
    .level      (a_level),
    .edge_pulse (a_pulse),
    .edge_sticky(a_sticky),
    .edge_count (a_count),
    .overflow   (a_ovf)
  );

  edge_detect_array #(
    .FILTER_LEN(3),
    .CNT_WIDTH (2)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .async_in   (b_in),
    .mode       (b_mode),
    .clear      (b_clear),
    .level      (b_level),
    .edge_pulse (b_pulse),
    .edge_sticky(b_sticky),
    .edge_count (b_count),
    .overflow   (b_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse latency counted from the cycle in which the input is driven.
  task automatic expect_pulse(input bit is_b, input int ch, input int dly);
    ev_t e;
    e.ch  = ch;
    e.cyc = cyc + dly;
    if (is_b) qb.push_back(e);
    else      qa.push_back(e);
  endtask

  task automatic tick();
    ev_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int ch = 0; ch < 2; ch++) begin
      if (a_pulse[ch] === 1'b1) begin
        check("pulse_a_expected", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          check("pulse_a_ch", e.ch, ch);
          check("pulse_a_cyc", e.cyc, cyc);
        end
      end
      if (b_pulse[ch] === 1'b1) begin
        check("pulse_b_expected", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          check("pulse_b_ch", e.ch, ch);
          check("pulse_b_cyc", e.cyc, cyc);
        end
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst     = 1'b1;
    a_in    = 2'b11;
    b_in    = 2'b11;
    a_clear = 2'b00;
    b_clear = 2'b00;
    a_mode  = 4'b1111;
    b_mode  = 4'b1110;
    ticks(2);
    check("rst_a_level", a_level, 2'b11);
    check("rst_a_pulse", a_pulse, 2'b00);
    check("rst_a_sticky", a_sticky, 2'b00);
    check("rst_a_count", a_count, 16'h0);
    check("rst_a_ovf", a_ovf, 2'b00);
    check("rst_b_level", b_level, 2'b11);
    check("rst_b_count", b_count, 4'h0);
    rst = 1'b0;
    ticks(2);

    // Defaults, both edges on ch0: fall seen after edge 3, then return high.
    a_in[0] = 1'b0;
    expect_pulse(0, 0, 3);
    ticks(2);
    check("a_lat_level_before", a_level[0], 1'b1);
    tick();
    check("a_lat_level_after", a_level[0], 1'b0);
    check("a_first_count", a_count[7:0], 8'd1);
    ticks(2);
    a_in[0] = 1'b1;
    expect_pulse(0, 0, 3);
    ticks(4);
    check("a_ch0_count", a_count[7:0], 8'd2);
    check("a_ch0_sticky", a_sticky[0], 1'b1);
    check("a_ch1_count_idle", a_count[15:8], 8'd0);

    // Mode masking on ch1: rising only.
    a_mode[3:2] = 2'b01;
    a_in[1] = 1'b0;
    ticks(4);
    check("mask_level_fall", a_level[1], 1'b0);
    check("mask_count_fall", a_count[15:8], 8'd0);
    check("mask_sticky_fall", a_sticky[1], 1'b0);
    a_in[1] = 1'b1;
    expect_pulse(0, 1, 3);
    ticks(4);
    check("mask_level_rise", a_level[1], 1'b1);
    check("mask_count_rise", a_count[15:8], 8'd1);
    check("mask_sticky_rise", a_sticky[1], 1'b1);

    // Simultaneous opposite transitions on both channels.
    a_mode = 4'b1111;
    a_in[1] = 1'b0;
    expect_pulse(0, 1, 3);
    ticks(4);
    a_in = 2'b10;
    expect_pulse(0, 0, 3);
    expect_pulse(0, 1, 3);
    ticks(3);
    check("dual_pulse", a_pulse, 2'b11);
    tick();
    check("dual_count0", a_count[7:0], 8'd3);
    check("dual_count1", a_count[15:8], 8'd3);
    a_in = 2'b11;
    expect_pulse(0, 0, 3);
    ticks(4);

    // FILTER_LEN=3, falling only on ch0: a 2-cycle glitch is rejected.
    b_in[0] = 1'b0;
    ticks(2);
    b_in[0] = 1'b1;
    ticks(8);
    check("glitch_level", b_level[0], 1'b1);
    check("glitch_count", b_count[1:0], 2'd0);
    check("glitch_sticky", b_sticky[0], 1'b0);

    // 3-cycle low: level falls after edge 5; the return rise is masked.
    b_in[0] = 1'b0;
    expect_pulse(1, 0, 5);
    ticks(3);
    b_in[0] = 1'b1;
    tick();
    check("filt_level_edge4", b_level[0], 1'b1);
    tick();
    check("filt_level_edge5", b_level[0], 1'b0);
    ticks(6);
    check("filt_level_back", b_level[0], 1'b1);
    check("filt_count", b_count[1:0], 2'd1);
    check("filt_sticky", b_sticky[0], 1'b1);

    // Second fall brings count to 2, then reset lands mid-filter.
    b_in[0] = 1'b0;
    expect_pulse(1, 0, 5);
    ticks(8);
    b_in[0] = 1'b1;
    ticks(10);
    check("pre_rst_count", b_count[1:0], 2'd2);
    b_in[0] = 1'b0;
    ticks(3);
    rst = 1'b1;
    b_in[0] = 1'b1;
    tick();
    check("mid_rst_b_level", b_level, 2'b11);
    check("mid_rst_b_count", b_count, 4'h0);
    check("mid_rst_b_sticky", b_sticky, 2'b00);
    check("mid_rst_b_pulse", b_pulse, 2'b00);
    check("mid_rst_a_count", a_count, 16'h0);
    check("mid_rst_a_sticky", a_sticky, 2'b00);
    rst = 1'b0;
    tick();
    check("post_rst_b_pulse", b_pulse, 2'b00);
    check("post_rst_a_pulse", a_pulse, 2'b00);
    ticks(8);
    check("post_rst_b_level", b_level[0], 1'b1);

    // Saturation on B ch1 (mode both, 2-bit counter).
    for (int k = 0; k < 3; k++) begin
      b_in[1] = ~b_in[1];
      expect_pulse(1, 1, 5);
      ticks(6);
    end
    check("sat_count3", b_count[3:2], 2'd3);
    check("sat_ovf_pre", b_ovf[1], 1'b0);
    b_in[1] = ~b_in[1];
    expect_pulse(1, 1, 5);
    ticks(4);
    check("sat_ovf_before_edge4", b_ovf[1], 1'b0);
    tick();
    check("sat_ovf_edge4", b_ovf[1], 1'b1);
    check("sat_count_hold", b_count[3:2], 2'd3);
    ticks(2);

    // Clear coinciding with the 5th edge keeps that edge.
    b_in[1] = 1'b0;
    expect_pulse(1, 1, 5);
    ticks(4);
    b_clear = 2'b10;
    tick();
    b_clear = 2'b00;
    check("clr_edge_count", b_count[3:2], 2'd1);
    check("clr_edge_ovf", b_ovf[1], 1'b0);
    check("clr_edge_sticky", b_sticky[1], 1'b1);
    check("clr_edge_ch0_untouched", b_count[1:0], 2'd0);

    // Clear alone zeroes reporting state but leaves level alone.
    b_clear = 2'b10;
    tick();
    b_clear = 2'b00;
    check("clr_count", b_count[3:2], 2'd0);
    check("clr_sticky", b_sticky[1], 1'b0);
    check("clr_ovf", b_ovf[1], 1'b0);
    check("clr_level", b_level[1], 1'b0);
    ticks(4);

    check("missed_pulses_a", qa.size(), 0);
    check("missed_pulses_b", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_detect_array.md
# edge_detect_array

Parametrised, multi-channel edge detector for the USB receive front end. Each channel synchronises an asynchronous line such as d_plus or d_minus, rejects glitches shorter than a programmable run length and tracks a filtered line level. Qualifying edges are reported three ways: a one-cycle pulse, a sticky flag and a saturating per-channel edge counter. The block replaces the single-bit edge_detect in front of the decoder and sync-byte detector.

## Interface
Parameters:
- CHANNELS, 2, number of independent input lines
- SYNC_STAGES, 2, synchroniser flops per channel (legal values 2..4)
- FILTER_LEN, 1, consecutive synchronised samples required before the level changes (legal values 1..15)
- CNT_WIDTH, 8, width of each per-channel edge counter
- RESET_LEVEL, 1, reset value of the synchroniser flops and of level (USB idle J state: d_plus high)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  reset, synchronous and active-high
- async_in  input  CHANNELS  raw asynchronous lines; bit i is channel i
- mode  input  2*CHANNELS  bits [2i+1:2i] select the qualifying edges for channel i: 00 none, 01 rising, 10 falling, 11 both
- clear  input  CHANNELS  synchronous per-channel clear of edge_sticky, edge_count and overflow
- level  output  CHANNELS  filtered, registered line level
- edge_pulse  output  CHANNELS  one-cycle strobe on each qualifying edge
- edge_sticky  output  CHANNELS  set by a qualifying edge, held until clear
- edge_count  output  CHANNELS*CNT_WIDTH  bits [i*CNT_WIDTH +: CNT_WIDTH] hold the qualifying-edge count for channel i; the counter saturates
- overflow  output  CHANNELS  sticky; set when a qualifying edge arrives while edge_count is at its maximum

## Operation
- Synchroniser:
  - A SYNC_STAGES-deep shift chain per channel.
  - Its last stage, s[i], is the only sampled view of async_in.
- Filter (per channel):
  - run_cnt has width ceil(log2(FILTER_LEN+1)).
  - Each cycle with s[i] != level[i]: if run_cnt == FILTER_LEN-1, then level[i] <= s[i] and run_cnt <= 0 (a "level change"); otherwise run_cnt increments.
  - Each cycle with s[i] == level[i]: run_cnt <= 0.
  - Result: any excursion of s[i] shorter than FILTER_LEN cycles produces no level change.
- Qualification: a level change is qualifying when it is 0->1 and mode bit 0 is set, or when it is 1->0 and mode bit 1 is set.
- Level tracking ignores mode. With mode 00 the level still follows the line, but no pulses or counts are produced.
- On a qualifying edge, all of the following happen in the same clock as the level update:
  - edge_pulse[i] is high for exactly that one cycle.
  - edge_sticky[i] <= 1.
  - edge_count increments by 1, or holds at 2^CNT_WIDTH-1 and sets overflow[i].
- clear[i] alone: edge_sticky, edge_count and overflow of channel i go to 0 on the next edge. It has no effect on level, run_cnt or the synchroniser.
- clear[i] in the same cycle as a qualifying edge: the edge is not lost. Result is edge_count = 1, edge_sticky = 1, overflow = 0, and edge_pulse fires.
- A mode change applies to the first level change evaluated after the new mode is registered on the port. It never generates a pulse by itself.
- Channels are fully independent. Simultaneous edges on several channels are all reported in the same cycle.

## Timing
- Reset values, one cycle after rst is sampled high:
  - synchroniser flops = RESET_LEVEL
  - level = {CHANNELS{RESET_LEVEL}}
  - run_cnt = 0
  - edge_pulse = 0, edge_sticky = 0, edge_count = 0, overflow = 0
- rst mid-filter or mid-count discards all progress. No pulse is emitted in the reset cycle or the cycle after it.
- Latency:
  - Count the first rising edge that samples the new async_in value as edge 1.
  - level and edge_pulse update after edge SYNC_STAGES+FILTER_LEN. With defaults this is edge 3.
- Minimum input pulse width that is reported: FILTER_LEN clock periods at s[i]. Shorter pulses are filtered.
- Back-to-back edges are separated by at least FILTER_LEN cycles, so edge_pulse is never high for two consecutive cycles unless FILTER_LEN == 1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Defaults, mode=11 on ch0:
  - Stimulus: reset, then drive async_in[0] 1->0, hold 5 cycles, then 0->1.
  - Required: level[0] falls after edge 3; a single edge_pulse[0]; after the return to 1, edge_count[0]=2 and edge_sticky[0]=1.
- FILTER_LEN=3, mode=10:
  - Stimulus: 2-cycle low glitch, then a 3-cycle low.
  - Required: no pulse for the glitch; level falls after edge 5 of the 3-cycle low; edge_count=1.
- Mode masking:
  - Stimulus: mode=01, then a falling edge followed by a rising edge.
  - Required: level follows both edges; exactly one edge_pulse, on the rise; edge_count=1.
- Saturation (CNT_WIDTH=2):
  - Stimulus: 4 qualifying edges.
  - Required: edge_count=3 with overflow set on the 4th edge.
  - Stimulus: assert clear together with a 5th edge.
  - Required: edge_count=1, overflow=0, edge_sticky=1.
- Reset mid-operation:
  - Stimulus: assert rst while run_cnt>0 and edge_count=2.
  - Required: all outputs at reset values on the next cycle; no edge_pulse in that cycle or the cycle after.
- Two channels:
  - Stimulus: drive simultaneous opposite transitions on ch0 and ch1 with mode=11.
  - Required: both edge_pulse bits high in the same cycle; counters independent.
